// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - shared SM4 width constants and output FSM state type
package sm4_pkg;
    localparam int SM4_BLOCK_W = 128;
    localparam int SM4_WORD_W  = 32;
    localparam int SM4_ENTRY_W = SM4_BLOCK_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } out_state_t;
endpackage

// File: rtl/sm4_sync_fifo.sv
// rtl/sm4_sync_fifo.sv - single-clock FIFO, head entry readable one edge after write
module sm4_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 129
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A write into a full FIFO still lands when the head leaves on the same edge.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sm4_axis_out_buf.sv
// rtl/sm4_axis_out_buf.sv - buffers 128-bit SM4 blocks and serialises them to 32-bit words
// Optional credit flow control: SM4_OUTBUF_CREDIT_EN
module sm4_axis_out_buf
    import sm4_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int FIFO_AW = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SM4_BLOCK_W-1:0] s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    input  logic                   issue,
    output logic                   credit_ok,
    output logic [SM4_WORD_W-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   overflow,
    input  logic                   clr_ovf
);
    out_state_t             state;
    logic [1:0]             idx;
    logic [SM4_BLOCK_W-1:0] sreg;
    logic                   blk_last;
    logic [SM4_ENTRY_W-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_AW:0]       fifo_count;
    logic                   pop;
    logic                   drop;
    logic                   adv;

    sm4_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (FIFO_AW),
        .W     (SM4_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (s_tvalid),
        .wdata ({s_tlast, s_tdata}),
        .rd    (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign adv  = m_axis_tvalid && m_axis_tready;
    assign pop  = !fifo_empty && ((state == ST_IDLE) || (adv && idx == 2'd3));
    assign drop = s_tvalid && fifo_full && !pop;
    assign m_axis_tdata = sreg[SM4_BLOCK_W-1 -: SM4_WORD_W];

    // The active word always sits in the top 32 bits; advancing shifts the block left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= 2'd0;
            sreg          <= '0;
            blk_last      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (pop) begin
            state         <= ST_SEND;
            idx           <= 2'd0;
            sreg          <= head[SM4_BLOCK_W-1:0];
            blk_last      <= head[SM4_BLOCK_W];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
        end else if (state == ST_SEND && adv) begin
            if (idx == 2'd3) begin
                state         <= ST_IDLE;
                idx           <= 2'd0;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end else begin
                idx          <= idx + 2'd1;
                sreg         <= {sreg[SM4_BLOCK_W-SM4_WORD_W-1:0], {SM4_WORD_W{1'b0}}};
                m_axis_tlast <= blk_last && (idx == 2'd2);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef SM4_OUTBUF_CREDIT_EN
    logic [FIFO_AW:0]   inflight;
    logic [FIFO_AW+1:0] occupancy;

    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight  <= '0;
            credit_ok <= 1'b0;
        end else begin
            if (issue && !s_tvalid && inflight != (FIFO_AW+1)'(DEPTH)) begin
                inflight <= inflight + 1'b1;
            end else if (s_tvalid && !issue && inflight != '0) begin
                inflight <= inflight - 1'b1;
            end
            credit_ok <= (occupancy < (FIFO_AW+2)'(DEPTH));
        end
    end
`else
    logic issue_unused;
    logic [FIFO_AW:0] count_unused;

    assign issue_unused = issue;
    assign count_unused = fifo_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_ok <= 1'b0;
        end else begin
            credit_ok <= 1'b1;
        end
    end
`endif
endmodule

// File: doc/sm4_axis_out_buf.md
SM4_AXIS_OUT_BUF -- requirements
Module: sm4_axis_out_buf

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 128-bit FIFO entries; legal values are powers of two, 32..256.
REQ-002 Parameter FIFO_AW, default 6, SHALL equal log2(DEPTH).
REQ-003 clk  in  1  clock; all logic is rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 s_tdata  in  128  result block from the SM4 core output stream; this stream has no ready.
REQ-006 s_tvalid  in  1  s_tdata valid for one cycle.
REQ-007 s_tlast  in  1  last block of the packet, qualified by s_tvalid.
REQ-008 issue  in  1  one-cycle pulse per block accepted into the SM4 core input (core tvalid & tready).
REQ-009 credit_ok  out  1  high when the upstream source may issue another block into the core.
REQ-010 m_axis_tdata  out  32  output word.
REQ-011 m_axis_tvalid  out  1  output word valid.
REQ-012 m_axis_tready  in  1  downstream ready.
REQ-013 m_axis_tlast  out  1  last word of the packet.
REQ-014 overflow  out  1  sticky flag: a block arrived while the FIFO was full.
REQ-015 clr_ovf  in  1  synchronous clear of overflow.

Function
REQ-016 A block SHALL be written to the FIFO (data plus tlast) on every cycle with s_tvalid=1 and the FIFO not full.
REQ-017 s_tvalid=1 with the FIFO full SHALL drop the block, leave the FIFO unchanged, and set overflow=1 on the next edge.
REQ-018 Every block SHALL be serialised into 4 words, MSB first: word0=[127:96], word1=[95:64], word2=[63:32], word3=[31:0].
REQ-019 m_axis_tlast SHALL be 1 only on word3 of a block written with tlast=1.
REQ-020 Output FSM: IDLE (no block loaded) and SEND (block loaded, word index 0..3).
REQ-021 IDLE -> SEND SHALL occur on the edge where the FIFO is non-empty; the head is popped into the output register and the index is set to 0.
REQ-022 In SEND, each m_axis_tvalid & m_axis_tready SHALL advance the index; on word3 acceptance, the FSM SHALL load the next block (index 0) in the same edge if the FIFO is non-empty, otherwise go to IDLE.
REQ-023 A sustained m_axis_tready=1 SHALL give one word per cycle with no bubbles across block boundaries.
REQ-024 m_axis_tdata and m_axis_tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 Latency: a block written into an empty FIFO at edge N SHALL present word0 with m_axis_tvalid=1 after edge N+1.
REQ-026 A write and a pop on the same edge SHALL both occur; the count is unchanged. A write on a full FIFO with a simultaneous pop SHALL be accepted, not dropped.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; the count range is 0..DEPTH.
REQ-028 clr_ovf=1 SHALL clear overflow unless a drop occurs in the same cycle; the drop wins.

Reset
REQ-029 While rst is asserted:
- FSM=IDLE, pointers=0, count=0, in-flight count=0.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0.
- credit_ok=0.
REQ-030 Reset asserted mid-packet SHALL discard all buffered and in-flight blocks; no partial word SHALL be emitted after release.
REQ-031 credit_ok SHALL rise no earlier than the first edge after rst deasserts.

Configuration
REQ-032 With SM4_OUTBUF_CREDIT_EN defined:
- An in-flight counter (0..DEPTH) SHALL increment on issue and decrement on s_tvalid; both on the same edge leave it unchanged.
- credit_ok SHALL be registered and SHALL equal (fifo count + in-flight) < DEPTH.
REQ-033 Without SM4_OUTBUF_CREDIT_EN:
- issue SHALL be ignored.
- credit_ok SHALL be 1 in every cycle after reset.
- overflow is the only protection.

Structure
REQ-034 A shared package sm4_pkg SHALL hold the SM4 block-width constant (128) and the output word-width constant (32).
REQ-035 Storage SHALL be one sub-module, sm4_sync_fifo: single clock, write/read/full/empty/count, first-word visible after one edge.

Verification
REQ-036 Single block 0x0123456789ABCDEFFEDCBA9876543210 with tlast=1 and tready=1 -> words 01234567, 89ABCDEF, FEDCBA98, 76543210 on consecutive cycles; tlast on the 4th word only.
REQ-037 Three back-to-back blocks with tready=1 -> 12 words with no bubbles and tlast only on the final word.
REQ-038 tready toggling 1,0,0,1,... across a block -> each word is held stable while stalled, in correct order, with none duplicated or lost.
REQ-039 tready=0 and DEPTH+1 blocks written -> the first DEPTH blocks are kept, the last is dropped, and overflow=1; clr_ovf pulse -> overflow=0.
REQ-040 Credit build with DEPTH=64: 64 issue pulses with no s_tvalid -> credit_ok=0; one s_tvalid plus one word3 drain -> credit_ok=1.
REQ-041 rst pulsed during word1 of a block -> m_axis_tvalid=0 next cycle and the buffer is empty; a new block after release is emitted from word0.
